// File: rtl/chip8_pkg.sv
// Shared types for the CHIP-8 RAM arbiter: requester IDs, lock FSM states
// and default RAM geometry.
package chip8_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {REQ_VGA, REQ_CPU, REQ_RND} req_id_e;

    typedef enum logic [1:0] {IDLE, LOCK_CPU, LOCK_RND} arb_state_e;

endpackage

// File: rtl/chip8_rr_pick.sv
// Two-way CPU/renderer tie picker. last_rnd = 1 means the renderer won the
// previous tie, so the CPU is favoured this time.
module chip8_rr_pick (
    input  logic cpu_req,
    input  logic rnd_req,
    input  logic last_rnd,
    output logic cpu_pick,
    output logic rnd_pick
);

    assign cpu_pick = cpu_req & (~rnd_req | last_rnd);
    assign rnd_pick = rnd_req & (~cpu_req | ~last_rnd);

endmodule

// File: rtl/chip8_ram_arbiter.sv
// Single-port RAM arbiter for VGA (highest priority, read-only), CPU and renderer,
// with bus locking. Define CHIP8_ARB_ROUND_ROBIN_EN for round-robin CPU/renderer ties.
module chip8_ram_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    input  logic              rnd_req,
    input  logic [ADDR_W-1:0] rnd_addr,
    input  logic              rnd_we,
    input  logic [DATA_W-1:0] rnd_wdata,
    input  logic              rnd_lock,
    output logic              vga_gnt,
    output logic              cpu_gnt,
    output logic              rnd_gnt,
    output logic              vga_rvalid,
    output logic              cpu_rvalid,
    output logic              rnd_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // After a forced release the former non-owner gets the next CPU/renderer slot.
    logic             yield_cpu_q, yield_cpu_d, yield_rnd_q, yield_rnd_d;
    logic             last_rnd, cpu_pick, rnd_pick;
    logic [ADDR_W-1:0] ram_addr;

`ifdef CHIP8_ARB_ROUND_ROBIN_EN
    req_id_e last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       last_q <= REQ_RND;
        else if (cpu_gnt) last_q <= REQ_CPU;
        else if (rnd_gnt) last_q <= REQ_RND;
    end

    assign last_rnd = (last_q == REQ_RND);
`else
    assign last_rnd = 1'b1;
`endif

    chip8_rr_pick u_pick (
        .cpu_req  (cpu_req),
        .rnd_req  (rnd_req),
        .last_rnd (last_rnd),
        .cpu_pick (cpu_pick),
        .rnd_pick (rnd_pick)
    );

    always_comb begin
        vga_gnt = 1'b0;
        cpu_gnt = 1'b0;
        rnd_gnt = 1'b0;
        if (reset) begin
            if (vga_req) begin
                vga_gnt = 1'b1;
            end else begin
                case (state_q)
                    LOCK_CPU: cpu_gnt = cpu_req;
                    LOCK_RND: rnd_gnt = rnd_req;
                    default: begin
                        if (yield_cpu_q && cpu_req)      cpu_gnt = 1'b1;
                        else if (yield_rnd_q && rnd_req) rnd_gnt = 1'b1;
                        else begin
                            cpu_gnt = cpu_pick;
                            rnd_gnt = rnd_pick;
                        end
                    end
                endcase
            end
        end
    end

    // cnt_q counts owner grants since lock entry, the entry grant included.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        yield_cpu_d = yield_cpu_q & cpu_req & ~(cpu_gnt | rnd_gnt);
        yield_rnd_d = yield_rnd_q & rnd_req & ~(cpu_gnt | rnd_gnt);
        case (state_q)
            LOCK_CPU: begin
                if (cpu_gnt) cnt_d = cnt_q + 1'b1;
                if (!cpu_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_d == CNT_W'(LOCK_MAX)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    yield_rnd_d = 1'b1;
                end
            end
            LOCK_RND: begin
                if (rnd_gnt) cnt_d = cnt_q + 1'b1;
                if (!rnd_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_d == CNT_W'(LOCK_MAX)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    yield_cpu_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                if (cpu_gnt && cpu_lock) begin
                    state_d = LOCK_CPU;
                    cnt_d   = CNT_W'(1);
                end else if (rnd_gnt && rnd_lock) begin
                    state_d = LOCK_RND;
                    cnt_d   = CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            yield_cpu_q <= 1'b0;
            yield_rnd_q <= 1'b0;
            vga_rvalid  <= 1'b0;
            cpu_rvalid  <= 1'b0;
            rnd_rvalid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            yield_cpu_q <= yield_cpu_d;
            yield_rnd_q <= yield_rnd_d;
            vga_rvalid  <= vga_gnt;
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            rnd_rvalid  <= rnd_gnt & ~rnd_we;
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (vga_gnt) begin
            ram_addr = vga_addr;
        end else if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_d    = cpu_wdata;
            ram_we   = cpu_we;
        end else if (rnd_gnt) begin
            ram_addr = rnd_addr;
            ram_d    = rnd_wdata;
            ram_we   = rnd_we;
        end
    end

    assign ram_read_address  = ram_addr;
    assign ram_write_address = ram_addr;
    assign rdata = (vga_rvalid | cpu_rvalid | rnd_rvalid) ? ram_q : '0;

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Bench for chip8_ram_arbiter: directed scenarios then randomized traffic,
// checked every cycle against a rule-level reference model and RAM image.
module tb_chip8_ram_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_req, cpu_req, rnd_req, cpu_we, rnd_we, cpu_lock, rnd_lock;
    logic [ADDR_W-1:0] vga_addr, cpu_addr, rnd_addr;
    logic [DATA_W-1:0] cpu_wdata, rnd_wdata;
    logic              vga_gnt, cpu_gnt, rnd_gnt, vga_rvalid, cpu_rvalid, rnd_rvalid;
    logic [DATA_W-1:0] rdata, ram_d, ram_q;
    logic [ADDR_W-1:0] ram_read_address, ram_write_address;
    logic              ram_we;

    int checks = 0;
    int errors = 0;

    // Reference model. Requester ids: 0 none, 1 VGA, 2 CPU, 3 renderer.
    int m_owner, m_cnt, m_last, m_yield, m_rv, m_g, dut_g;
    logic [DATA_W-1:0] m_rdata;
    logic [DATA_W-1:0] ref_mem [0:4095];
    bit                ref_wr  [0:4095];
    logic [DATA_W-1:0] mem     [0:4095];
    bit                wr      [0:4095];
    int s2 [4];
    int s3 [20];

    always #5 clk = ~clk;

    chip8_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_lock(cpu_lock),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_we(rnd_we), .rnd_wdata(rnd_wdata), .rnd_lock(rnd_lock),
        .vga_gnt(vga_gnt), .cpu_gnt(cpu_gnt), .rnd_gnt(rnd_gnt),
        .vga_rvalid(vga_rvalid), .cpu_rvalid(cpu_rvalid), .rnd_rvalid(rnd_rvalid),
        .rdata(rdata), .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return (a == 12'h200) ? 8'h12 : (a[7:0] ^ 8'h5A);
    endfunction

    // chip8_ram stand-in: synchronous write, registered read.
    always @(posedge clk) begin
        ram_q <= wr[ram_read_address] ? mem[ram_read_address] : init_val(ram_read_address);
        if (ram_we) begin
            mem[ram_write_address] <= ram_d;
            wr[ram_write_address]  <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant();
        if (!reset) return 0;
        if (vga_req) return 1;
        if (m_owner == 2) return cpu_req ? 2 : 0;
        if (m_owner == 3) return rnd_req ? 3 : 0;
        if (m_yield == 2 && cpu_req) return 2;
        if (m_yield == 3 && rnd_req) return 3;
        if (cpu_req && rnd_req) begin
`ifdef CHIP8_ARB_ROUND_ROBIN_EN
            return (m_last == 2) ? 3 : 2;
`else
            return 2;
`endif
        end
        if (cpu_req) return 2;
        if (rnd_req) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_last = 3; m_yield = 0; m_rv = 0; m_g = 0;
    endtask

    task automatic check_cycle();
        int g;
        logic exp_we;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        g = exp_grant();
        m_g = g;
        dut_g = vga_gnt ? 1 : cpu_gnt ? 2 : rnd_gnt ? 3 : 0;
        exp_we = (g == 2 && cpu_we) || (g == 3 && rnd_we);
        ea = (g == 1) ? vga_addr : (g == 2) ? cpu_addr : rnd_addr;
        ed = (g == 2) ? cpu_wdata : rnd_wdata;
        chk("vga_gnt", 32'(vga_gnt), 32'(g == 1));
        chk("cpu_gnt", 32'(cpu_gnt), 32'(g == 2));
        chk("rnd_gnt", 32'(rnd_gnt), 32'(g == 3));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (g != 0) begin
            chk("ram_read_address", 32'(ram_read_address), 32'(ea));
            chk("ram_write_address", 32'(ram_write_address), 32'(ea));
            if (exp_we) chk("ram_d", 32'(ram_d), 32'(ed));
        end
        if (!reset) begin
            chk("rst_rvalid", 32'({vga_rvalid, cpu_rvalid, rnd_rvalid}), 32'(0));
            chk("rst_rdata", 32'(rdata), 32'(0));
            model_reset();
            return;
        end
        chk("vga_rvalid", 32'(vga_rvalid), 32'(m_rv == 1));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv == 2));
        chk("rnd_rvalid", 32'(rnd_rvalid), 32'(m_rv == 3));
        if (m_rv != 0) chk("rdata", 32'(rdata), 32'(m_rdata));
        m_rv = 0;
        if (g != 0 && !exp_we) begin
            m_rv = g;
            m_rdata = ref_wr[ea] ? ref_mem[ea] : init_val(ea);
        end
        if (exp_we) begin
            ref_mem[ea] = ed;
            ref_wr[ea]  = 1'b1;
        end
        if (g == 2 || g == 3) begin
            m_last = g;
            m_yield = 0;
        end else if ((m_yield == 2 && !cpu_req) || (m_yield == 3 && !rnd_req)) begin
            m_yield = 0;
        end
        if (m_owner != 0) begin
            if (g == m_owner) m_cnt++;
            if (!((m_owner == 2) ? cpu_lock : rnd_lock)) begin
                m_owner = 0; m_cnt = 0;
            end else if (m_cnt == LOCK_MAX) begin
                m_yield = 5 - m_owner; m_owner = 0; m_cnt = 0;
            end
        end else if ((g == 2 && cpu_lock) || (g == 3 && rnd_lock)) begin
            m_owner = g; m_cnt = 1;
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are checked at negedge.
    task automatic cyc();
        #4;
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        vga_req = 0; cpu_req = 0; rnd_req = 0; cpu_we = 0; rnd_we = 0; cpu_lock = 0; rnd_lock = 0;
        vga_addr = '0; cpu_addr = '0; rnd_addr = '0; cpu_wdata = '0; rnd_wdata = '0;
    endtask

    task automatic reset_pulse();
        clr();
        reset = 0;
        cyc();
        reset = 1;
        cyc();
    endtask

    // Requesters keep req/addr/we/wdata until the model says they were granted.
    task automatic drive_random();
        if (!(vga_req && m_g != 1)) begin
            vga_req  = ($urandom_range(0, 3) == 0);
            vga_addr = ADDR_W'($urandom_range(0, 63));
        end
        if (!(cpu_req && m_g != 2)) begin
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_addr  = ADDR_W'($urandom_range(0, 63));
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_wdata = DATA_W'($urandom);
        end
        if (!(rnd_req && m_g != 3)) begin
            rnd_req   = 1'($urandom_range(0, 1));
            rnd_addr  = ADDR_W'($urandom_range(0, 63));
            rnd_we    = ($urandom_range(0, 2) == 0);
            rnd_wdata = DATA_W'($urandom);
        end
        cpu_lock = ($urandom_range(0, 3) != 0);
        rnd_lock = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int n_rnd, first_cpu;
        model_reset();
        clr();
        reset = 0;
        @(posedge clk);
        #1;
        // Reset holds every output low even with all requests raised.
        vga_req = 1; cpu_req = 1; rnd_req = 1; cpu_lock = 1;
        cyc();
        cyc();
        clr();
        reset = 1;
        cyc();

        // VGA read of 0x200.
        vga_req = 1; vga_addr = 12'h200;
        cyc();
        chk("s1_vga_gnt", 32'(dut_g), 32'(1));
        clr();
        chk("s1_vga_rvalid", 32'(vga_rvalid), 32'(1));
        chk("s1_rdata", 32'(rdata), 32'h12);
        cyc();

        // Continuous CPU/renderer tie straight after reset.
        reset_pulse();
        cpu_req = 1; cpu_addr = 12'h010; rnd_req = 1; rnd_addr = 12'h020;
        for (int i = 0; i < 4; i++) begin
            cyc();
            s2[i] = dut_g;
        end
`ifdef CHIP8_ARB_ROUND_ROBIN_EN
        chk("s2_tie0", 32'(s2[0]), 32'(2));
        chk("s2_tie1", 32'(s2[1]), 32'(3));
        chk("s2_tie2", 32'(s2[2]), 32'(2));
        chk("s2_tie3", 32'(s2[3]), 32'(3));
`else
        for (int i = 0; i < 4; i++) chk("s2_fixed", 32'(s2[i]), 32'(2));
`endif
        clr();
        cyc();

        // Renderer holds the lock for 20 cycles; CPU joins after the first grant.
        rnd_req = 1; rnd_lock = 1; rnd_addr = 12'h100;
        cyc();
        s3[0] = dut_g;
        cpu_req = 1; cpu_addr = 12'h101;
        for (int i = 1; i < 20; i++) begin
            cyc();
            s3[i] = dut_g;
        end
        n_rnd = 0;
        first_cpu = -1;
        for (int i = 0; i < 20; i++) begin
            if (first_cpu < 0 && s3[i] == 3) n_rnd++;
            if (first_cpu < 0 && s3[i] == 2) first_cpu = i;
        end
        chk("s3_rnd_grants", 32'(n_rnd), 32'(LOCK_MAX));
        chk("s3_first_cpu", 32'(first_cpu), 32'(LOCK_MAX));
        clr();
        cyc();
        cyc();

        // CPU write blocked by VGA, then performed; read back through VGA.
        vga_req = 1; vga_addr = 12'h010;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h300; cpu_wdata = 8'hAB;
        cyc();
        chk("s4_vga_first", 32'(dut_g), 32'(1));
        vga_req = 0;
        #4;
        chk("s4_ram_we", 32'(ram_we), 32'(1));
        chk("s4_addr", 32'(ram_write_address), 32'h300);
        chk("s4_ram_d", 32'(ram_d), 32'hAB);
        #(-4 + 4) cyc_tail();
        clr();
        vga_req = 1; vga_addr = 12'h300;
        cyc();
        clr();
        chk("s4_readback", 32'(rdata), 32'hAB);
        cyc();

        // Reset lands the cycle after a CPU read grant.
        cpu_req = 1; cpu_addr = 12'h200;
        cyc();
        chk("s5_cpu_gnt", 32'(dut_g), 32'(2));
        reset = 0;
        #1;
        chk("s5_no_rvalid", 32'(cpu_rvalid), 32'(0));
        chk("s5_rdata", 32'(rdata), 32'(0));
        #3;
        check_cycle();
        @(posedge clk);
        #1;
        cyc();
        clr();
        reset = 1;
        cyc();

        for (int i = 0; i < 1500; i++) begin
            drive_random();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Finishes a cycle whose negedge point has already been reached.
    task automatic cyc_tail();
        check_cycle();
        @(posedge clk);
        #1;
    endtask

endmodule

// File: doc/chip8_ram_arbiter.md
CHIP8_RAM_ARBITER -- requirements
Module: chip8_ram_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- LOCK_MAX, 16, maximum consecutive locked grants before the lock is forcibly released.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- vga_req, in, 1, VGA pixel-generator read request.
- vga_addr, in, ADDR_W, VGA read address.
- cpu_req, in, 1, CPU request.
- cpu_addr, in, ADDR_W, CPU address.
- cpu_we, in, 1, CPU write strobe.
- cpu_wdata, in, DATA_W, CPU write data.
- cpu_lock, in, 1, CPU bus-lock request.
- rnd_req, in, 1, renderer request.
- rnd_addr, in, ADDR_W, renderer address.
- rnd_we, in, 1, renderer write strobe.
- rnd_wdata, in, DATA_W, renderer write data.
- rnd_lock, in, 1, renderer bus-lock request.
- vga_gnt, cpu_gnt, rnd_gnt, out, 1 each, grant for this cycle.
- vga_rvalid, cpu_rvalid, rnd_rvalid, out, 1 each, read data valid.
- rdata, out, DATA_W, read data, shared by all requesters.
- ram_read_address, out, ADDR_W, to chip8_ram.
- ram_write_address, out, ADDR_W, to chip8_ram.
- ram_d, out, DATA_W, to chip8_ram.
- ram_we, out, 1, to chip8_ram.
- ram_q, in, DATA_W, from chip8_ram (1-cycle read latency).

Function
REQ-003 At most one grant SHALL be high per cycle. Grants are combinational from the current requests and the registered state.
REQ-004 vga_req SHALL always win, including during a lock. VGA is read-only.
REQ-005 Without VGA contention, arbitration between CPU and renderer SHALL follow the REQ-014 policy, unless a lock is held.
REQ-006 The granted requester's address SHALL drive both ram_read_address and ram_write_address in the grant cycle.
- ram_we = gnt & we of the granted requester; ram_d = its wdata.
- When nothing is granted, ram_we = 0.
REQ-007 A granted read SHALL assert the matching *_rvalid exactly one cycle later, with rdata = ram_q. A granted write SHALL produce no rvalid.
REQ-008 FSM states:
- IDLE -> LOCK_CPU when cpu_gnt & cpu_lock.
- IDLE -> LOCK_RND when rnd_gnt & rnd_lock.
- LOCK_x -> IDLE when the owner deasserts lock, or when the lock counter reaches LOCK_MAX.
REQ-009 In LOCK_x, the non-owner of CPU/renderer SHALL NOT be granted. The owner is granted whenever it requests and VGA does not.
REQ-010 The lock counter SHALL reset to 0 on lock entry and increment on each owner grant. Forced release on reaching LOCK_MAX SHALL grant the non-owner next if it is requesting.
REQ-011 Simultaneous requests from all three: VGA SHALL be granted. The CPU/renderer ordering state SHALL be unchanged.
REQ-012 A request held low SHALL never be granted. A requester SHALL hold req and addr stable until it sees gnt.

Reset
REQ-013 While reset = 0:
- All gnt, rvalid and ram_we outputs SHALL be 0; rdata SHALL be 0.
- The FSM SHALL be in IDLE with the lock counter at 0.
- The last-winner register SHALL be set to renderer, so the CPU wins the first tie.
- A read in flight when reset asserts SHALL produce no rvalid.

Configuration
REQ-014 Macro CHIP8_ARB_ROUND_ROBIN_EN selects the CPU/renderer tie policy:
- Defined: on a CPU/renderer tie, grant the one not granted last.
- Undefined: fixed priority, CPU over renderer. The last-winner register SHALL be omitted.

Structure
REQ-015 A shared package chip8_pkg SHALL hold:
- the requester-ID enum (VGA, CPU, RND);
- the FSM state enum (IDLE, LOCK_CPU, LOCK_RND);
- the ADDR_W/DATA_W defaults.
REQ-016 Sub-module chip8_rr_pick SHALL implement the 2-way tie picker. There SHALL be no other sub-modules.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- VGA read 0x200, RAM holds 0x12 -> vga_gnt in cycle 0, vga_rvalid in cycle 1 with rdata = 0x12.
- CPU and renderer request continuously with round-robin enabled -> grants alternate CPU, RND, CPU, RND; CPU first after reset.
- Same stimulus with the macro undefined -> CPU granted every cycle, rnd_gnt never asserted.
- Renderer locks for 20 cycles with LOCK_MAX = 16 while CPU also requests -> 16 renderer grants, then cpu_gnt.
- CPU write of 0xAB to 0x300 while vga_req is high -> VGA granted first, then ram_we with address 0x300 and ram_d = 0xAB.
- Reset asserted one cycle after a CPU read grant -> cpu_rvalid never asserts and all outputs read 0.
